// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if
//   Parallel-word valid/ready handshake into the serial bit feeder.
//   Signals:
//     din        word to serialize (master -> slave)
//     din_valid  din is valid this cycle (master -> slave)
//     din_ready  slave can take a word this cycle (slave -> master)
//   Modports: master (word producer), slave (serial_bit_feeder).
interface serial_bit_feeder_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Takes parallel words over a valid/ready handshake and shifts them out one bit per
//   enabled clock on x_o/x_valid_o. A one-word holding buffer lets back-to-back frames
//   stream with no gap bits. x_o feeds a sequence detector's serial input directly.
//   Parameters:
//     WIDTH      data bits per word (>= 2)
//     MSB_FIRST  1: din[WIDTH-1] goes out first; 0: din[0] goes out first
//   Ports:
//     clk_i          rising-edge clock
//     reset_i        synchronous active-high reset
//     in_if          slave side of the word handshake (din, din_valid, din_ready)
//     bit_en_i       shift strobe; the stream advances only on edges where it is 1
//     x_o            current serial bit
//     x_valid_o      x_o carries a frame bit
//     frame_start_o  x_o is bit 0 of a frame
//     busy_o         x_valid_o or holding buffer full
//   Build option: define PARITY_EN to append an even-parity bit to every frame
//   (frame becomes WIDTH+1 bits).
module serial_bit_feeder #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   serial_bit_feeder_if.slave in_if,
   input  logic               bit_en_i,
   output logic               x_o,
   output logic               x_valid_o,
   output logic               frame_start_o,
   output logic               busy_o
);

   localparam int unsigned     CntW     = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastData = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] buf_q;
   logic             buf_full_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CntW-1:0]  cnt_q;
`ifdef PARITY_EN
   logic             parity_q;
`endif

   logic accept;
   logic advance;
   logic frame_end;
   logic reload;
   logic head_bit;

   always_comb begin
      head_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      // Accept only looks at buf_full_q, so din_ready has no path from din_valid.
      accept    = in_if.din_valid && !buf_full_q;
      advance   = bit_en_i && (state_q != StIdle);
`ifdef PARITY_EN
      frame_end = bit_en_i && (state_q == StParity);
`else
      frame_end = bit_en_i && (state_q == StShift) && (cnt_q == LastData);
`endif
      // Reload needs a full buffer and accept needs an empty one, so the two never
      // coincide; that is what makes zero-gap streaming safe with a single buffer.
      reload    = buf_full_q && ((state_q == StIdle) || frame_end);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shreg_q    <= '0;
         cnt_q      <= '0;
`ifdef PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            buf_q      <= in_if.din;
            buf_full_q <= 1'b1;
         end
         if (reload) begin
            shreg_q    <= buf_q;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StShift;
`ifdef PARITY_EN
            parity_q   <= ^buf_q;
`endif
         end else if (frame_end) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else if (advance) begin
            shreg_q <= MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + 1'b1;
`ifdef PARITY_EN
            if ((state_q == StShift) && (cnt_q == LastData)) begin
               state_q <= StParity;
            end
`endif
         end
      end
   end

   // All outputs decode registered state only.
   always_comb begin
      unique case (state_q)
         StShift:  x_o = head_bit;
`ifdef PARITY_EN
         StParity: x_o = parity_q;
`endif
         default:  x_o = 1'b0;
      endcase
      x_valid_o       = (state_q != StIdle);
      frame_start_o   = x_valid_o && (cnt_q == '0);
      busy_o          = x_valid_o || buf_full_q;
      in_if.din_ready = !buf_full_q;
   end

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

`ifdef PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic clk = 1'b0;
   logic reset;
   logic bit_en;
   logic x_m, xv_m, fs_m, busy_m;
   logic x_l, xv_l, fs_l, busy_l;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_bit_feeder_if #(.WIDTH(8)) m_if ();
   serial_bit_feeder_if #(.WIDTH(8)) l_if ();

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .in_if         (m_if),
      .bit_en_i      (bit_en),
      .x_o           (x_m),
      .x_valid_o     (xv_m),
      .frame_start_o (fs_m),
      .busy_o        (busy_m)
   );

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk_i         (clk),
      .reset_i       (reset),
      .in_if         (l_if),
      .bit_en_i      (bit_en),
      .x_o           (x_l),
      .x_valid_o     (xv_l),
      .frame_start_o (fs_l),
      .busy_o        (busy_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Frame bit j of word: data bits in shift order, then even parity.
   function automatic logic exp_bit(input logic [7:0] w, input int j, input bit msb);
      if (j >= 8) return ^w;
      return msb ? w[7-j] : w[j];
   endfunction

   // Present one word for one cycle; returns at the negedge where bit 0 is on x.
   task automatic send(input logic [7:0] w, input bit lsb);
      if (lsb) begin l_if.din = w; l_if.din_valid = 1'b1; end
      else     begin m_if.din = w; m_if.din_valid = 1'b1; end
      step();
      l_if.din_valid = 1'b0;
      m_if.din_valid = 1'b0;
      step();
   endtask

   task automatic frame(input string tag, input logic [7:0] w, input bit lsb);
      for (int j = 0; j < FL; j++) begin
         chk({tag, "_xv"}, lsb ? xv_l : xv_m, 1);
         chk({tag, "_x"},  lsb ? x_l : x_m, exp_bit(w, j, !lsb));
         chk({tag, "_fs"}, lsb ? fs_l : fs_m, (j == 0) ? 1 : 0);
         chk({tag, "_busy"}, lsb ? busy_l : busy_m, 1);
         step();
      end
      chk({tag, "_end_xv"}, lsb ? xv_l : xv_m, 0);
      chk({tag, "_end_busy"}, lsb ? busy_l : busy_m, 0);
   endtask

   initial begin
      reset = 1'b1;
      bit_en = 1'b1;
      m_if.din = 8'h00; m_if.din_valid = 1'b0;
      l_if.din = 8'h00; l_if.din_valid = 1'b0;
      step();
      chk("rst_xv", xv_m, 0);
      chk("rst_x", x_m, 0);
      chk("rst_fs", fs_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_rdy", m_if.din_ready, 1);
      reset = 1'b0;

      // Test 1: 0x90 MSB first; load edge sits between accept and first bit.
      m_if.din = 8'h90; m_if.din_valid = 1'b1;
      step();
      m_if.din_valid = 1'b0;
      chk("t1_acc_xv", xv_m, 0);
      chk("t1_acc_rdy", m_if.din_ready, 0);
      chk("t1_acc_busy", busy_m, 1);
      step();
      frame("t1", 8'h90, 1'b0);

      // Test 2: A5 then 3C back to back with valid held; no gap between frames.
      m_if.din = 8'hA5; m_if.din_valid = 1'b1;
      step();
      chk("t2_rdy_pre", m_if.din_ready, 0);
      m_if.din = 8'h3C;
      step();
      for (int i = 0; i < 2 * FL; i++) begin
         if (i == 1) m_if.din_valid = 1'b0;
         chk("t2_xv", xv_m, 1);
         chk("t2_x", x_m, exp_bit((i < FL) ? 8'hA5 : 8'h3C, i % FL, 1'b1));
         chk("t2_fs", fs_m, ((i % FL) == 0) ? 1 : 0);
         chk("t2_rdy", m_if.din_ready, (i == 0 || i >= FL) ? 1 : 0);
         step();
      end
      chk("t2_end_xv", xv_m, 0);

      // Test 3: bit_en alternating 0/1 holds every bit for two cycles.
      send(8'hF0, 1'b0);
      for (int k = 0; k < 2 * FL; k++) begin
         chk("t3_xv", xv_m, 1);
         chk("t3_x", x_m, exp_bit(8'hF0, k / 2, 1'b1));
         chk("t3_fs", fs_m, (k < 2) ? 1 : 0);
         chk("t3_busy", busy_m, 1);
         bit_en = (k % 2 == 1);
         step();
      end
      bit_en = 1'b1;
      chk("t3_end_xv", xv_m, 0);
      chk("t3_end_busy", busy_m, 0);

      // Test 4: reset while bit 3 is on x; din offered during reset is ignored.
      send(8'h5A, 1'b0);
      for (int j = 0; j < 3; j++) step();
      chk("t4_bit3", x_m, exp_bit(8'h5A, 3, 1'b1));
      reset = 1'b1;
      m_if.din = 8'hFF; m_if.din_valid = 1'b1;
      step();
      reset = 1'b0;
      m_if.din_valid = 1'b0;
      chk("t4_xv", xv_m, 0);
      chk("t4_x", x_m, 0);
      chk("t4_rdy", m_if.din_ready, 1);
      chk("t4_busy", busy_m, 0);
      chk("t4_fs", fs_m, 0);
      send(8'h81, 1'b0);
      frame("t4_new", 8'h81, 1'b0);

      // Test 5: LSB-first instance, 0x09 -> 1,0,0,1,0,0,0,0.
      send(8'h09, 1'b1);
      frame("t5", 8'h09, 1'b1);

`ifdef PARITY_EN
      // Test 6: parity bit after data (0x07 -> 1, 0x03 -> 0).
      send(8'h07, 1'b0);
      frame("t6a", 8'h07, 1'b0);
      send(8'h03, 1'b0);
      frame("t6b", 8'h03, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
